// File: rtl/ibex_xif_instr_aligner.sv
// Instruction aligner: turns word-aligned fetch data into one RV32/RVC instruction per handshake.
// Optional compressed-instruction counter enabled by defining IBEX_XIF_ALIGNER_PERF_EN.
module ibex_xif_instr_aligner #(
    parameter logic [31:0] BootAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_is_compressed_o,
    output logic        instr_err_o,
    output logic        instr_err_plus2_o
`ifdef IBEX_XIF_ALIGNER_PERF_EN
    ,
    output logic [31:0] perf_compressed_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SKIP  = 2'd1,
        STASH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] stash_q, stash_d;
    logic        stash_err_q, stash_err_d;
    logic [31:0] pc_q, pc_d;
    logic        stash_alone;
    logic        instr_hs;
    logic        unused_flush_addr_bit;

    assign unused_flush_addr_bit = flush_addr_i[0];

    // A compressed or faulty stash is emitted by itself, without waiting for the next word.
    assign stash_alone           = stash_err_q || (stash_q[1:0] != 2'b11);
    assign instr_is_compressed_o = instr_rdata_o[1:0] != 2'b11;
    assign instr_hs              = instr_valid_o & instr_ready_i;
    assign instr_addr_o          = pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            stash_q     <= 16'h0000;
            stash_err_q <= 1'b0;
            pc_q        <= BootAddr;
        end else begin
            state_q     <= state_d;
            stash_q     <= stash_d;
            stash_err_q <= stash_err_d;
            pc_q        <= pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stash_d     = stash_q;
        stash_err_d = stash_err_q;
        pc_d        = pc_q;
        if (flush_i) begin
            state_d     = flush_addr_i[1] ? SKIP : EMPTY;
            pc_d        = {flush_addr_i[31:1], 1'b0};
            stash_err_d = 1'b0;
        end else begin
            if (instr_hs) begin
                pc_d = pc_q + (instr_is_compressed_o ? 32'd2 : 32'd4);
            end
            if (fetch_ready_o) begin
                stash_d     = fetch_rdata_i[31:16];
                stash_err_d = fetch_err_i;
            end
            case (state_q)
                EMPTY:   if (instr_hs && instr_is_compressed_o) state_d = STASH;
                SKIP:    if (fetch_ready_o) state_d = STASH;
                STASH:   if (instr_hs && stash_alone) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        instr_valid_o     = 1'b0;
        fetch_ready_o     = 1'b0;
        instr_rdata_o     = 32'h0000_0000;
        instr_err_o       = 1'b0;
        instr_err_plus2_o = 1'b0;
        case (state_q)
            EMPTY: begin
                instr_valid_o = fetch_valid_i;
                instr_rdata_o = (fetch_rdata_i[1:0] != 2'b11) ?
                                {16'h0000, fetch_rdata_i[15:0]} : fetch_rdata_i;
                instr_err_o   = fetch_err_i;
                fetch_ready_o = fetch_valid_i & instr_ready_i;
            end
            SKIP: begin
                fetch_ready_o = fetch_valid_i;
            end
            STASH: begin
                if (stash_alone) begin
                    instr_valid_o = 1'b1;
                    instr_rdata_o = {16'h0000, stash_q};
                    instr_err_o   = stash_err_q;
                end else begin
                    instr_valid_o     = fetch_valid_i;
                    instr_rdata_o     = {fetch_rdata_i[15:0], stash_q};
                    instr_err_o       = fetch_err_i;
                    instr_err_plus2_o = fetch_err_i;
                    fetch_ready_o     = fetch_valid_i & instr_ready_i;
                end
            end
            default: ;
        endcase
        // A redirect or reset kills both handshakes in the current cycle.
        if (flush_i || !rst_ni) begin
            instr_valid_o     = 1'b0;
            fetch_ready_o     = 1'b0;
            instr_err_o       = 1'b0;
            instr_err_plus2_o = 1'b0;
        end
    end

`ifdef IBEX_XIF_ALIGNER_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_compressed_cnt_o <= 32'h0000_0000;
        end else if (instr_hs && instr_is_compressed_o && (perf_compressed_cnt_o != 32'hFFFF_FFFF)) begin
            perf_compressed_cnt_o <= perf_compressed_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ibex_xif_instr_aligner.sv
// Scoreboard bench for ibex_xif_instr_aligner: a halfword-stream model predicts every instruction.
module tb_ibex_xif_instr_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = 32'h0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_rdata = 32'h0;
    logic        fetch_err = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_rdata;
    logic [31:0] instr_addr;
    logic        instr_comp;
    logic        instr_err;
    logic        instr_p2;
`ifdef IBEX_XIF_ALIGNER_PERF_EN
    logic [31:0] perf_cnt;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        comp;
        logic        err;
        logic        p2;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] seg_words[$];
    logic        seg_errs[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] perf_model = 32'h0;

    ibex_xif_instr_aligner #(.BootAddr(32'h0000_0000)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .flush_i               (flush),
        .flush_addr_i          (flush_addr),
        .fetch_valid_i         (fetch_valid),
        .fetch_ready_o         (fetch_ready),
        .fetch_rdata_i         (fetch_rdata),
        .fetch_err_i           (fetch_err),
        .instr_valid_o         (instr_valid),
        .instr_ready_i         (instr_ready),
        .instr_rdata_o         (instr_rdata),
        .instr_addr_o          (instr_addr),
        .instr_is_compressed_o (instr_comp),
        .instr_err_o           (instr_err),
        .instr_err_plus2_o     (instr_p2)
`ifdef IBEX_XIF_ALIGNER_PERF_EN
        ,
        .perf_compressed_cnt_o (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    endtask

    // Monitor: every instruction handshake pops one prediction.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_instr: got %h at %h, want no instruction", instr_rdata, instr_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("instr {rdata,addr,comp,err,plus2}",
                      {instr_rdata, instr_addr, instr_comp, instr_err, instr_p2}, mon_e);
                if (mon_e.comp && perf_model != 32'hFFFF_FFFF) perf_model = perf_model + 32'd1;
            end
        end
        if (fetch_ready) check("fetch_ready_needs_valid", fetch_valid, 1'b1);
    end

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    task automatic load(input logic [31:0] w, input logic e);
        seg_words.push_back(w);
        seg_errs.push_back(e);
    endtask

    // Reference: walk the halfword stream; pc advances 2 for RVC, 4 otherwise.
    task automatic build_expected(input logic [31:0] addr);
        logic [15:0] h[$];
        logic        e[$];
        int          i;
        logic [31:0] pc;
        exp_t        x;
        foreach (seg_words[k]) begin
            h.push_back(seg_words[k][15:0]);
            e.push_back(seg_errs[k]);
            h.push_back(seg_words[k][31:16]);
            e.push_back(seg_errs[k]);
        end
        i  = addr[1] ? 1 : 0;
        pc = {addr[31:1], 1'b0};
        while (i < h.size()) begin
            x.addr = pc;
            x.p2   = 1'b0;
            if (h[i][1:0] != 2'b11) begin
                x.rdata = {16'h0, h[i]}; x.comp = 1'b1; x.err = e[i];
                i += 1; pc += 32'd2;
            end else if (i % 2 == 0) begin
                x.rdata = {h[i+1], h[i]}; x.comp = 1'b0; x.err = e[i];
                i += 2; pc += 32'd4;
            end else if (e[i]) begin
                x.rdata = {16'h0, h[i]}; x.comp = 1'b0; x.err = 1'b1;
                i += 1; pc += 32'd4;
            end else if (i + 1 < h.size()) begin
                x.rdata = {h[i+1], h[i]}; x.comp = 1'b0; x.err = e[i+1]; x.p2 = e[i+1];
                i += 2; pc += 32'd4;
            end else begin
                break;
            end
            exp_q.push_back(x);
        end
    endtask

    task automatic do_flush(input logic [31:0] a);
        flush       = 1'b1;
        flush_addr  = a;
        fetch_valid = 1'($urandom_range(1));
        fetch_rdata = $urandom;
        fetch_err   = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        check("flush_blocks {valid,fready}", {instr_valid, fetch_ready}, 2'b00);
        @(posedge clk); #1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        check("flush_pc", instr_addr, {a[31:1], 1'b0});
        seg_words.delete();
        seg_errs.delete();
    endtask

    task automatic applyStimulus(input bit rnd);
        int head = 0;
        int cyc  = 0;
        bit acc;
        while ((head < seg_words.size() || exp_q.size() != 0) && cyc < 400) begin
            if (!fetch_valid && head < seg_words.size() && (!rnd || $urandom_range(3) != 0)) begin
                fetch_valid = 1'b1;
                fetch_rdata = seg_words[head];
                fetch_err   = seg_errs[head];
            end
            instr_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            @(negedge clk);
            acc = fetch_valid && fetch_ready;
            @(posedge clk); #1;
            if (acc) begin
                head++;
                fetch_valid = 1'b0;
            end
            cyc++;
        end
        check("segment_drained {words,pending}", {32'(head), 32'(exp_q.size())}, {32'(seg_words.size()), 32'd0});
        exp_q.delete();
        fetch_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
`ifdef IBEX_XIF_ALIGNER_PERF_EN
        check("perf_count", perf_cnt, perf_model);
`endif
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        repeat (2) @(posedge clk);
        #1;
        check("reset {valid,fready,err,plus2}", {instr_valid, fetch_ready, instr_err, instr_p2}, 4'b0000);
        check("reset_pc", instr_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two RVC in one word; the word is consumed in the first cycle only.
        do_flush(32'h100);
        load(32'h0001_4501, 1'b0);
        build_expected(32'h100);
        fetch_valid = 1'b1; fetch_rdata = 32'h0001_4501; fetch_err = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        check("t1_fready_first", fetch_ready, 1'b1);
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("t1_second {valid,fready}", {instr_valid, fetch_ready}, 2'b10);
        @(posedge clk); #1;
        check("t1_all_seen", 32'(exp_q.size()), 32'd0);

        // Straddling 32-bit instruction.
        do_flush(32'h200);
        load(32'h1237_0001, 1'b0);
        load(32'hABCD_5678, 1'b0);
        build_expected(32'h200);
        applyStimulus(1'b0);

        // Start on the upper halfword: SKIP for one cycle.
        do_flush(32'h302);
        load(32'h4501_FFFF, 1'b0);
        build_expected(32'h302);
        fetch_valid = 1'b1; fetch_rdata = 32'h4501_FFFF; fetch_err = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        check("t3_skip {valid,fready}", {instr_valid, fetch_ready}, 2'b01);
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("t3_emit_valid", instr_valid, 1'b1);
        @(posedge clk); #1;
        check("t3_next_pc", instr_addr, 32'h304);
        check("t3_all_seen", 32'(exp_q.size()), 32'd0);

        // Straddle where the second word is faulty.
        do_flush(32'h700);
        load(32'hFFFF_0001, 1'b0);
        load(32'h0000_0000, 1'b1);
        build_expected(32'h700);
        applyStimulus(1'b0);

        // Faulty uncompressed stash goes out alone; the next word must wait.
        do_flush(32'h800);
        load(32'hFFFF_0001, 1'b1);
        load(32'h0005_0009, 1'b0);
        build_expected(32'h800);
        applyStimulus(1'b0);

        // Stall, then flush while the instruction is still pending.
        do_flush(32'h400);
        fetch_valid = 1'b1; fetch_rdata = 32'h0001_4501; fetch_err = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        check("t6_c1 {valid,rdata,fready}", {instr_valid, instr_rdata, fetch_ready}, {1'b1, 32'h0000_4501, 1'b0});
        @(posedge clk); #1;
        flush = 1'b1; flush_addr = 32'h500;
        @(negedge clk);
        check("t6_c2 {valid,fready}", {instr_valid, fetch_ready}, 2'b00);
        @(posedge clk); #1;
        flush = 1'b0; fetch_valid = 1'b0;
        check("t6_c3_pc", instr_addr, 32'h500);
`ifdef IBEX_XIF_ALIGNER_PERF_EN
        check("t6_perf_unchanged", perf_cnt, perf_model);
`endif

        // PC wrap-around.
        do_flush(32'hFFFF_FFFC);
        load(32'h0001_4501, 1'b0);
        load(32'h0009_0003, 1'b0);
        build_expected(32'hFFFF_FFFC);
        applyStimulus(1'b0);

        // Reset mid-operation drops a pending uncompressed stash.
        do_flush(32'h600);
        load(32'hFFFF_0001, 1'b0);
        build_expected(32'h600);
        applyStimulus(1'b0);
        rst_n = 1'b0;
        perf_model = 32'h0;
        #2;
        check("midreset {valid,fready,pc}", {instr_valid, fetch_ready, instr_addr}, {2'b00, 32'h0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        seg_words.delete(); seg_errs.delete();
        load(32'h0000_0009, 1'b0);
        build_expected(32'h0);
        applyStimulus(1'b0);

        // Randomized segments.
        for (int s = 0; s < 30; s++) begin
            a = $urandom;
            do_flush(a);
            n = $urandom_range(6, 1);
            for (int k = 0; k < n; k++) load({rand_hw(), rand_hw()}, ($urandom_range(7) == 0));
            build_expected(a);
            applyStimulus(1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

endmodule
